// File: rtl/spi_slave_control.sv
// SPI mode-3 slave controller: synchronises the SPI pins into clk_i,
// shifts LSB-first bytes in and out, packs received bytes into a 32-bit
// word and feeds transmit data from a single-entry 32-bit buffer.
module spi_slave_control #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        spi_clk_i,
    input  logic        spi_cs_n_i,
    input  logic        spi_mosi_i,
    output logic        spi_miso_o,
    input  logic [31:0] tx_data_i,
    input  logic        tx_valid_i,
    output logic        tx_ready_o,
    output logic [31:0] rx_data_o,
    output logic [2:0]  rx_bytes_valid_o,
    output logic        rx_byte_strobe_o,
    output logic        frame_done_o,
    output logic        tx_underrun_o,
    output logic        busy_o
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] flush;

    logic sck_cur;
    logic cs_cur;
    logic mosi_cur;
    logic sck_prev;
    logic cs_prev;
    logic cs_armed;

    logic sck_rise;
    logic sck_fall;
    logic cs_rise;
    logic cs_fall;

    logic start_frame;
    logic end_frame;
    logic sck_rise_act;
    logic sck_fall_act;

    logic [2:0]  bit_idx;
    logic [1:0]  byte_idx;
    logic [7:0]  rx_shift;
    logic [7:0]  rx_byte_next;
    logic [31:0] tx_shift;
    logic [31:0] tx_buf;
    logic        tx_full;
    logic        tx_xfer;
    logic        byte_complete;
    logic        word_wrap;
    logic        tx_load;

    assign sck_cur  = sck_sync[SYNC_STAGES-1];
    assign cs_cur   = cs_sync[SYNC_STAGES-1];
    assign mosi_cur = mosi_sync[SYNC_STAGES-1];

    // Pin synchronisers; they reset to the idle bus levels, and the flush
    // chain marks when the synchronised values truly reflect the pins.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sck_sync  <= '1;
            cs_sync   <= '1;
            mosi_sync <= '1;
            flush     <= '0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_clk_i};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n_i};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
            flush     <= {flush[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // Previous-value flops for edge detection; chip select is only armed
    // once it has genuinely been seen high, so a CS held low through reset
    // cannot look like a fresh falling edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sck_prev <= 1'b1;
            cs_prev  <= 1'b1;
            cs_armed <= 1'b0;
        end else begin
            sck_prev <= sck_cur;
            cs_prev  <= cs_cur;
            cs_armed <= cs_armed | (flush[SYNC_STAGES-1] & cs_cur);
        end
    end

    assign sck_rise = ~sck_prev & sck_cur;
    assign sck_fall = sck_prev & ~sck_cur;
    assign cs_rise  = ~cs_prev & cs_cur;
    assign cs_fall  = cs_armed & cs_prev & ~cs_cur;

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and per-cycle control strobes; SPI clock edges only
    // count while a frame is active and CS is not being released.
    always_comb begin
        state_next   = state;
        start_frame  = 1'b0;
        end_frame    = 1'b0;
        sck_rise_act = 1'b0;
        sck_fall_act = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_next  = ACTIVE;
                    start_frame = 1'b1;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    state_next = IDLE;
                    end_frame  = 1'b1;
                end else begin
                    sck_rise_act = sck_rise;
                    sck_fall_act = sck_fall;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Receive byte with the bit being sampled this cycle merged in.
    always_comb begin
        rx_byte_next          = rx_shift;
        rx_byte_next[bit_idx] = mosi_cur;
    end

    assign byte_complete = sck_rise_act & (bit_idx == 3'd7);
    assign word_wrap     = byte_complete & (byte_idx == 2'd3);
    assign tx_load       = start_frame | word_wrap;
    assign tx_xfer       = tx_valid_i & ~tx_full;
    assign tx_ready_o    = ~tx_full;
    assign busy_o        = (state == ACTIVE);

    // Bit/byte counters, receive packing, MISO drive and event pulses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bit_idx          <= 3'd0;
            byte_idx         <= 2'd0;
            rx_shift         <= 8'h00;
            rx_data_o        <= 32'h0;
            rx_bytes_valid_o <= 3'd0;
            rx_byte_strobe_o <= 1'b0;
            frame_done_o     <= 1'b0;
            spi_miso_o       <= 1'b1;
        end else begin
            rx_byte_strobe_o <= 1'b0;
            frame_done_o     <= end_frame;
            if (start_frame) begin
                bit_idx          <= 3'd0;
                byte_idx         <= 2'd0;
                rx_data_o        <= 32'h0;
                rx_bytes_valid_o <= 3'd0;
                spi_miso_o       <= 1'b1;
            end else if (end_frame) begin
                bit_idx    <= 3'd0;
                byte_idx   <= 2'd0;
                spi_miso_o <= 1'b1;
            end else begin
                if (sck_fall_act) begin
                    spi_miso_o <= tx_shift[{byte_idx, bit_idx}];
                end
                if (sck_rise_act) begin
                    rx_shift <= rx_byte_next;
                    bit_idx  <= bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        if (byte_idx == 2'd0) begin
                            rx_data_o <= {24'h0, rx_byte_next};
                        end else begin
                            rx_data_o[{byte_idx, 3'b000} +: 8] <= rx_byte_next;
                        end
                        rx_bytes_valid_o <= {1'b0, byte_idx} + 3'd1;
                        rx_byte_strobe_o <= 1'b1;
                        byte_idx         <= byte_idx + 2'd1;
                    end
                end
            end
        end
    end

    // Transmit buffer and shift word; a handshake landing in the same cycle
    // as a load refills the buffer for the following load.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tx_shift      <= 32'hFFFF_FFFF;
            tx_buf        <= 32'h0;
            tx_full       <= 1'b0;
            tx_underrun_o <= 1'b0;
        end else begin
            tx_underrun_o <= tx_load & ~tx_full;
            if (tx_load) begin
                tx_shift <= tx_full ? tx_buf : 32'hFFFF_FFFF;
            end
            if (tx_xfer) begin
                tx_buf <= tx_data_i;
            end
            tx_full <= (tx_full & ~tx_load) | tx_xfer;
        end
    end

endmodule

// File: tb/tb_spi_slave_control.sv
// Self-checking bench for spi_slave_control: drives an SPI master on the
// pins, predicts MISO bits, receive words and frame ends from a simple
// frame-level model, and compares them in independent monitor processes.
module tb_spi_slave_control;

    localparam int HALF = 6;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        spi_clk_i;
    logic        spi_cs_n_i;
    logic        spi_mosi_i;
    logic        spi_miso_o;
    logic [31:0] tx_data_i;
    logic        tx_valid_i;
    logic        tx_ready_o;
    logic [31:0] rx_data_o;
    logic [2:0]  rx_bytes_valid_o;
    logic        rx_byte_strobe_o;
    logic        frame_done_o;
    logic        tx_underrun_o;
    logic        busy_o;

    int checks = 0;
    int failures = 0;

    logic        exp_miso_q[$];
    logic [34:0] exp_rx_q[$];
    logic [34:0] exp_done_q[$];
    int          exp_underruns = 0;
    int          act_underruns = 0;

    logic [31:0] m_txq[$];
    logic        m_active = 1'b0;
    int          m_bits = 0;
    logic [31:0] m_word = 32'hFFFF_FFFF;
    logic [7:0]  m_bytes[$];
    logic [7:0]  m_cur_byte = 8'h00;

    spi_slave_control #(.SYNC_STAGES(2)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .spi_clk_i        (spi_clk_i),
        .spi_cs_n_i       (spi_cs_n_i),
        .spi_mosi_i       (spi_mosi_i),
        .spi_miso_o       (spi_miso_o),
        .tx_data_i        (tx_data_i),
        .tx_valid_i       (tx_valid_i),
        .tx_ready_o       (tx_ready_o),
        .rx_data_o        (rx_data_o),
        .rx_bytes_valid_o (rx_bytes_valid_o),
        .rx_byte_strobe_o (rx_byte_strobe_o),
        .frame_done_o     (frame_done_o),
        .tx_underrun_o    (tx_underrun_o),
        .busy_o           (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic waitCycles(input int n);
        for (int i = 0; i < n; i++) @(posedge clk_i);
    endtask

    // Next tx word: the buffered word if one was handed over, else all ones.
    task automatic modelLoad();
        if (m_txq.size() > 0) begin
            m_word = m_txq.pop_front();
        end else begin
            m_word = 32'hFFFF_FFFF;
            exp_underruns++;
        end
    endtask

    // Receive word: the bytes of the current 4-byte group packed in lanes.
    function automatic logic [34:0] modelRx();
        int n;
        int grp;
        logic [31:0] w;
        n = m_bytes.size();
        if (n == 0) return 35'h0;
        grp = ((n - 1) / 4) * 4;
        w = 32'h0;
        for (int j = grp; j < n; j++) w[8*(j-grp) +: 8] = m_bytes[j];
        return {3'(n - grp), w};
    endfunction

    task automatic loadTx(input logic [31:0] w);
        int n;
        n = 0;
        @(posedge clk_i) #1;
        tx_data_i  = w;
        tx_valid_i = 1'b1;
        while (tx_ready_o !== 1'b1 && n < 50) begin
            @(posedge clk_i) #1;
            n++;
        end
        if (n >= 50) begin
            checkOutput("tx_ready_timeout", {31'b0, tx_ready_o}, 32'h1);
        end else begin
            @(posedge clk_i) #1;
            m_txq.push_back(w);
        end
        tx_valid_i = 1'b0;
    endtask

    task automatic csFall();
        @(posedge clk_i) #1;
        spi_cs_n_i = 1'b0;
        m_active   = 1'b1;
        m_bits     = 0;
        m_bytes.delete();
        modelLoad();
        waitCycles(HALF);
    endtask

    task automatic csRise();
        @(posedge clk_i) #1;
        if (m_active) exp_done_q.push_back(modelRx());
        spi_cs_n_i = 1'b1;
        m_active   = 1'b0;
        waitCycles(HALF + 2);
    endtask

    // One SPI bit: falling edge with new MOSI, then rising edge.
    task automatic applyStimulus(input logic mosi);
        @(posedge clk_i) #1;
        spi_clk_i  = 1'b0;
        spi_mosi_i = mosi;
        exp_miso_q.push_back(m_active ? m_word[m_bits % 32] : 1'b1);
        waitCycles(HALF);
        if (m_active) begin
            m_cur_byte[m_bits % 8] = mosi;
            if (m_bits % 8 == 7) begin
                m_bytes.push_back(m_cur_byte);
                exp_rx_q.push_back(modelRx());
            end
        end
        @(posedge clk_i) #1;
        spi_clk_i = 1'b1;
        if (m_active) begin
            m_bits++;
            if (m_bits % 32 == 0) modelLoad();
        end
        waitCycles(HALF);
    endtask

    task automatic sendByte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) applyStimulus(b[i]);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_miso"},   {31'b0, spi_miso_o}, 32'h1);
        checkOutput({tag, "_ready"},  {31'b0, tx_ready_o}, 32'h1);
        checkOutput({tag, "_rx"},     rx_data_o, 32'h0);
        checkOutput({tag, "_valid"},  {29'b0, rx_bytes_valid_o}, 32'h0);
        checkOutput({tag, "_busy"},   {31'b0, busy_o}, 32'h0);
        checkOutput({tag, "_pulses"}, {29'b0, rx_byte_strobe_o, frame_done_o, tx_underrun_o}, 32'h0);
    endtask

    // MISO monitor: the master samples on each rising SPI clock edge.
    always @(posedge spi_clk_i) begin
        if (exp_miso_q.size() > 0) begin
            checkOutput("miso", {31'b0, spi_miso_o}, {31'b0, exp_miso_q.pop_front()});
        end
    end

    // Event monitor: byte strobes, frame ends and underrun pulses.
    always @(negedge clk_i) begin
        logic [34:0] e;
        if (rx_byte_strobe_o === 1'b1) begin
            if (exp_rx_q.size() == 0) begin
                checkOutput("rx_strobe_unexpected", 32'h1, 32'h0);
            end else begin
                e = exp_rx_q.pop_front();
                checkOutput("rx_data", rx_data_o, e[31:0]);
                checkOutput("rx_valid", {29'b0, rx_bytes_valid_o}, {29'b0, e[34:32]});
            end
        end
        if (frame_done_o === 1'b1) begin
            if (exp_done_q.size() == 0) begin
                checkOutput("frame_done_unexpected", 32'h1, 32'h0);
            end else begin
                e = exp_done_q.pop_front();
                checkOutput("done_rx_data", rx_data_o, e[31:0]);
                checkOutput("done_rx_valid", {29'b0, rx_bytes_valid_o}, {29'b0, e[34:32]});
                checkOutput("done_busy", {31'b0, busy_o}, 32'h0);
            end
        end
        if (tx_underrun_o === 1'b1) act_underruns++;
    end

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [7:0]  b4;
        logic [7:0]  b5;
        logic [7:0]  b0;
        int          nbits;
        int          midpos;

        rst_i      = 1'b1;
        spi_clk_i  = 1'b1;
        spi_cs_n_i = 1'b1;
        spi_mosi_i = 1'b1;
        tx_data_i  = 32'h0;
        tx_valid_i = 1'b0;
        waitCycles(3);
        #1;
        checkResetOutputs("reset");
        @(posedge clk_i) #1;
        rst_i = 1'b0;
        waitCycles(4);

        // Known word out, known word in.
        loadTx(32'hA5C3_0F81);
        csFall();
        sendByte(8'h78);
        sendByte(8'h56);
        sendByte(8'h34);
        sendByte(8'h12);
        csRise();
        checkOutput("known_rx_data", rx_data_o, 32'h1234_5678);
        checkOutput("known_rx_valid", {29'b0, rx_bytes_valid_o}, 32'h4);
        checkOutput("known_underruns", 32'(act_underruns), 32'(exp_underruns));

        // Frame without transmit data.
        csFall();
        sendByte(8'($urandom));
        sendByte(8'($urandom));
        csRise();
        checkOutput("empty_tx_underruns", 32'(act_underruns), 32'(exp_underruns));

        // Six bytes with the second word supplied mid-frame.
        loadTx($urandom);
        csFall();
        sendByte(8'($urandom));
        sendByte(8'($urandom));
        loadTx($urandom);
        sendByte(8'($urandom));
        sendByte(8'($urandom));
        b4 = 8'($urandom);
        b5 = 8'($urandom);
        sendByte(b4);
        sendByte(b5);
        csRise();
        checkOutput("six_rx_data", rx_data_o, {16'h0, b5, b4});
        checkOutput("six_rx_valid", {29'b0, rx_bytes_valid_o}, 32'h2);
        checkOutput("six_ready", {31'b0, tx_ready_o}, 32'h1);

        // CS released after 13 bits.
        csFall();
        b0 = 8'($urandom);
        sendByte(b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'($urandom));
        csRise();
        checkOutput("partial_rx_data", rx_data_o, {24'h0, b0});
        checkOutput("partial_rx_valid", {29'b0, rx_bytes_valid_o}, 32'h1);
        checkOutput("partial_busy", {31'b0, busy_o}, 32'h0);

        // Reset in the middle of a byte with CS held low.
        loadTx($urandom);
        csFall();
        for (int i = 0; i < 3; i++) applyStimulus(1'($urandom));
        @(posedge clk_i) #2;
        rst_i = 1'b1;
        #1;
        checkResetOutputs("midreset");
        m_active = 1'b0;
        m_txq.delete();
        waitCycles(2);
        #1;
        rst_i = 1'b0;
        waitCycles(4);
        sendByte(8'($urandom));
        checkOutput("post_reset_busy", {31'b0, busy_o}, 32'h0);
        checkOutput("post_reset_valid", {29'b0, rx_bytes_valid_o}, 32'h0);
        csRise();
        csFall();
        checkOutput("reentry_busy", {31'b0, busy_o}, 32'h1);
        sendByte(8'($urandom));
        csRise();
        checkOutput("reentry_underruns", 32'(act_underruns), 32'(exp_underruns));

        // Random frames with random preloads and mid-frame loads.
        for (int f = 0; f < 6; f++) begin
            if ($urandom_range(0, 1) == 1 && m_txq.size() == 0) loadTx($urandom);
            csFall();
            nbits  = $urandom_range(0, 72);
            midpos = $urandom_range(1, 40);
            for (int i = 0; i < nbits; i++) begin
                if (i == midpos && m_txq.size() == 0 && $urandom_range(0, 1) == 1) loadTx($urandom);
                applyStimulus(1'($urandom));
            end
            csRise();
        end
        checkOutput("random_underruns", 32'(act_underruns), 32'(exp_underruns));

        waitCycles(10);
        checkOutput("miso_queue_drained", 32'(exp_miso_q.size()), 32'h0);
        checkOutput("rx_queue_drained", 32'(exp_rx_q.size()), 32'h0);
        checkOutput("done_queue_drained", 32'(exp_done_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
